// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared FSM encoding, default width and route helper for the
//               packet-aware 1-to-2 stream demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int C_DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROUTE0 = 2'd1;
    localparam logic [1:0] ROUTE1 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ROUTE0 = ROUTE0,
        ST_ROUTE1 = ROUTE1
    } state_t;

    // Only the first beat of a packet looks at sel; afterwards the state owns it.
    function automatic logic route_of(input state_t state, input logic sel);
        logic route;
        unique case (state)
            ST_ROUTE0: route = 1'b0;
            ST_ROUTE1: route = 1'b1;
            default:   route = sel;
        endcase
        return route;
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1_to_2_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_2_if
// Description : Stream-in / two-stream-out bundle with debug packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1_to_2_if #(
    parameter int WIDTH = demux_pkg::C_DEFAULT_WIDTH
);
    logic             sel;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_last;
    logic             out0_valid;
    logic             out0_ready;

    logic [WIDTH-1:0] out1_data;
    logic             out1_last;
    logic             out1_valid;
    logic             out1_ready;

    logic [7:0]       pkt_cnt0;
    logic [7:0]       pkt_cnt1;

    modport master (
        output sel, in_data, in_last, in_valid, out0_ready, out1_ready,
        input  in_ready,
        input  out0_data, out0_last, out0_valid,
        input  out1_data, out1_last, out1_valid,
        input  pkt_cnt0, pkt_cnt1
    );

    modport slave (
        input  sel, in_data, in_last, in_valid, out0_ready, out1_ready,
        output in_ready,
        output out0_data, out0_last, out0_valid,
        output out1_data, out1_last, out1_valid,
        output pkt_cnt0, pkt_cnt1
    );

endinterface : demux_1_to_2_if
`default_nettype wire

// File: rtl/demux_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_reg
// Description : One-entry output register with load/drain control and an
//               8-bit delivered-packet counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_out_reg #(
    parameter int WIDTH = demux_pkg::C_DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_last,
    input  wire logic             i_ready,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_valid,
    output logic      [7:0]       o_pkt_cnt
);

    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             r_valid;
    logic [7:0]       r_pkt_cnt;
    logic             w_drain;

    assign w_drain = r_valid & i_ready;

    // A load in the same cycle as a drain refills the slot without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= 8'd0;
        end else if (w_drain && r_last) begin
            r_pkt_cnt <= r_pkt_cnt + 8'd1;
        end
    end

    assign o_data    = r_data;
    assign o_last    = r_last;
    assign o_valid   = r_valid;
    assign o_pkt_cnt = r_pkt_cnt;

endmodule : demux_out_reg
`default_nettype wire

// File: rtl/demux_1_to_2.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_to_2
// Description : Packet-aware 1-to-2 stream demultiplexer; the route is latched
//               on a packet's first beat and held until its last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_to_2
    import demux_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst,
    demux_1_to_2_if.slave   bus
);

    state_t r_state;
    state_t w_state_next;
    logic   w_route;
    logic   w_in_ready;
    logic   w_accept;
    logic   w_load0;
    logic   w_load1;

    assign w_route = route_of(r_state, bus.sel);

    // Ready looks only at the routed channel so a stalled idle channel never blocks.
    assign w_in_ready = w_route ? (!bus.out1_valid | bus.out1_ready)
                                : (!bus.out0_valid | bus.out0_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_load0    = w_accept & !w_route;
    assign w_load1    = w_accept &  w_route;

    assign bus.in_ready = w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (bus.in_last) begin
                w_state_next = ST_IDLE;
            end else begin
                w_state_next = w_route ? ST_ROUTE1 : ST_ROUTE0;
            end
        end
    end

    demux_out_reg #(
        .WIDTH (WIDTH)
    ) u_out0 (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load0),
        .i_data    (bus.in_data),
        .i_last    (bus.in_last),
        .i_ready   (bus.out0_ready),
        .o_data    (bus.out0_data),
        .o_last    (bus.out0_last),
        .o_valid   (bus.out0_valid),
        .o_pkt_cnt (bus.pkt_cnt0)
    );

    demux_out_reg #(
        .WIDTH (WIDTH)
    ) u_out1 (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load1),
        .i_data    (bus.in_data),
        .i_last    (bus.in_last),
        .i_ready   (bus.out1_ready),
        .o_data    (bus.out1_data),
        .o_last    (bus.out1_last),
        .o_valid   (bus.out1_valid),
        .o_pkt_cnt (bus.pkt_cnt1)
    );

endmodule : demux_1_to_2
`default_nettype wire

// File: tb/tb_demux_1_to_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_to_2
// Description : Directed self-checking bench for the 1-to-2 packet demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_to_2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    demux_1_to_2_if #(.WIDTH(8)) bus ();

    demux_1_to_2 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l);
        bus.in_valid = v;
        bus.sel      = s;
        bus.in_data  = d;
        bus.in_last  = l;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_v0",   bus.out0_valid, 0);
        check("rst_v1",   bus.out1_valid, 0);
        check("rst_d0",   bus.out0_data,  0);
        check("rst_l1",   bus.out1_last,  0);
        check("rst_c0",   bus.pkt_cnt0,   0);
        check("rst_c1",   bus.pkt_cnt1,   0);
        check("rst_rdy",  bus.in_ready,   1);
        check("rst_st",   dut.r_state,    2'd0);

        // 3-beat packet to out0
        drive(1'b1, 1'b0, 8'hA1, 1'b0); step();
        check("p1_v0",  bus.out0_valid, 1);
        check("p1_d0",  bus.out0_data,  8'hA1);
        check("p1_v1",  bus.out1_valid, 0);
        drive(1'b1, 1'b0, 8'hA2, 1'b0); step();
        check("p1_d1",  bus.out0_data,  8'hA2);
        drive(1'b1, 1'b0, 8'hA3, 1'b1); step();
        check("p1_d2",  bus.out0_data,  8'hA3);
        check("p1_l2",  bus.out0_last,  1);
        check("p1_v1b", bus.out1_valid, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();
        check("p1_v0e", bus.out0_valid, 0);
        check("p1_cnt", bus.pkt_cnt0,   1);
        check("p1_c1",  bus.pkt_cnt1,   0);

        // sel toggles mid-packet: whole packet stays on out0
        drive(1'b1, 1'b0, 8'hB1, 1'b0); step();
        check("p2_d0",  bus.out0_data,  8'hB1);
        drive(1'b1, 1'b1, 8'hB2, 1'b0); step();
        check("p2_v0",  bus.out0_valid, 1);
        check("p2_d1",  bus.out0_data,  8'hB2);
        check("p2_v1",  bus.out1_valid, 0);
        drive(1'b1, 1'b1, 8'hB3, 1'b1); step();
        check("p2_d2",  bus.out0_data,  8'hB3);
        check("p2_v1b", bus.out1_valid, 0);
        drive(1'b1, 1'b1, 8'hC1, 1'b1); step();
        check("p3_v1",  bus.out1_valid, 1);
        check("p3_d1",  bus.out1_data,  8'hC1);
        check("p3_v0",  bus.out0_valid, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();
        check("p3_c0",  bus.pkt_cnt0,   2);
        check("p3_c1",  bus.pkt_cnt1,   1);

        // out0 stalled while full
        bus.out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hD1, 1'b0); step();
        check("st_d0",  bus.out0_data,  8'hD1);
        drive(1'b1, 1'b0, 8'hD2, 1'b0); #1;
        check("st_rdy", bus.in_ready,   0);
        step();
        check("st_hold1", bus.out0_data,  8'hD1);
        check("st_hv1",   bus.out0_valid, 1);
        step();
        check("st_hold2", bus.out0_data,  8'hD1);
        bus.out0_ready = 1'b1; #1;
        check("st_rdy1", bus.in_ready,  1);
        step();
        check("st_d1",  bus.out0_data,  8'hD2);
        drive(1'b1, 1'b0, 8'hD3, 1'b1); step();
        check("st_d2",  bus.out0_data,  8'hD3);
        check("st_l2",  bus.out0_last,  1);
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();
        check("st_v0e", bus.out0_valid, 0);
        check("st_c0",  bus.pkt_cnt0,   3);

        // out1 stalled with a beat, new packet flows to out0
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 8'hE1, 1'b1); step();
        check("ind_v1", bus.out1_valid, 1);
        drive(1'b1, 1'b0, 8'hF1, 1'b0); #1;
        check("ind_rdy", bus.in_ready,  1);
        step();
        check("ind_d0", bus.out0_data,  8'hF1);
        drive(1'b1, 1'b0, 8'hF2, 1'b1); #1;
        check("ind_rdy2", bus.in_ready, 1);
        step();
        check("ind_d0b", bus.out0_data,  8'hF2);
        check("ind_v1b", bus.out1_valid, 1);
        check("ind_d1",  bus.out1_data,  8'hE1);
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();
        check("ind_c0",  bus.pkt_cnt0,   4);
        check("ind_c1h", bus.pkt_cnt1,   1);
        bus.out1_ready = 1'b1; step();
        check("ind_v1e", bus.out1_valid, 0);
        check("ind_c1",  bus.pkt_cnt1,   2);

        // 512 back-to-back single-beat packets, counters wrap from reset
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            logic [7:0] prev;
            prev = 8'(i - 1);
            if (i > 0) begin
                if (((i - 1) & 1) == 0) begin
                    check("b2b_v0", bus.out0_valid, 1);
                    check("b2b_d0", bus.out0_data,  prev);
                    if (i > 1) check("b2b_o1", bus.out1_valid, 0);
                end else begin
                    check("b2b_v1", bus.out1_valid, 1);
                    check("b2b_d1", bus.out1_data,  prev);
                    check("b2b_o0", bus.out0_valid, 0);
                end
            end
            if (i == 256) begin
                check("b2b_mc0", bus.pkt_cnt0, 128);
                check("b2b_mc1", bus.pkt_cnt1, 127);
            end
            drive(1'b1, 1'(i & 1), 8'(i), 1'b1); #1;
            check("b2b_rdy", bus.in_ready, 1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();
        check("wrap_c0", bus.pkt_cnt0, 0);
        check("wrap_c1", bus.pkt_cnt1, 0);

        // Reset in the middle of a 4-beat packet
        drive(1'b1, 1'b1, 8'h71, 1'b0); step();
        drive(1'b1, 1'b1, 8'h72, 1'b0); step();
        check("mr_d1",  bus.out1_data, 8'h72);
        check("mr_st",  dut.r_state,   2'd2);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h00, 1'b0); step();
        rst = 1'b0;
        check("mr_v0",  bus.out0_valid, 0);
        check("mr_v1",  bus.out1_valid, 0);
        check("mr_st0", dut.r_state,    2'd0);
        check("mr_d1z", bus.out1_data,  0);
        drive(1'b1, 1'b0, 8'h81, 1'b0); step();
        check("mr_nv0", bus.out0_valid, 1);
        check("mr_nd0", bus.out0_data,  8'h81);
        check("mr_nv1", bus.out1_valid, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_1_to_2
`default_nettype wire

// File: doc/demux_1_to_2.md
# demux_1_to_2

Packet-aware 1-to-2 stream demultiplexer: the distribution-side counterpart of the 2-to-1 selector. It accepts a valid/ready stream with a `last` marker and steers each packet to one of two output channels, chosen by `sel` at the packet's first beat. `sel` is locked for the rest of the packet. Each output has a one-entry register stage, so a stalled channel never corrupts the other. Per-channel packet counters support debug.

## Interface
- `WIDTH`, 8, data width in bits.
- `clk`  in  1  rising-edge clock, single domain.
- `rst`  in  1  synchronous, active-high reset.
- `sel`  in  1  channel select, 0 → out0, 1 → out1; sampled only on a packet's first beat.
- `in_data`  in  WIDTH  input beat data.
- `in_last`  in  1  marks the final beat of a packet.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out0_data` / `out1_data`  out  WIDTH  channel data.
- `out0_last` / `out1_last`  out  1  channel last marker.
- `out0_valid` / `out1_valid`  out  1  channel beat present.
- `out0_ready` / `out1_ready`  in  1  downstream accepts.
- `pkt_cnt0` / `pkt_cnt1`  out  8  packets fully delivered per channel.

## Operation
- Accept = `in_valid & in_ready`. Channel accept = `outN_valid & outN_ready`.
- FSM states:
  - `IDLE`: no packet in progress.
  - `ROUTE0`: packet locked to out0.
  - `ROUTE1`: packet locked to out1.
- Route: in `IDLE`, route = `sel`. In `ROUTEn`, route = n, and `sel` is ignored.
- Transitions:
  - `IDLE` → `ROUTE{sel}` on accept with `in_last`=0.
  - `IDLE` stays `IDLE` on accept with `in_last`=1 (single-beat packet).
  - `ROUTEn` → `IDLE` on accept with `in_last`=1.
  - No accept: state holds.
- `in_ready` = `!outR_valid | outR_ready`, where R is the current route. This is combinational from `outR_ready`, so full throughput is available.
- Channel register n, updated each cycle:
  - Load `in_data`/`in_last` and set valid, on an accept routed to n.
  - Else clear valid on a channel accept.
  - Else hold.
  - Load and channel accept in the same cycle: load wins, no bubble.
- Non-routed channel drains independently. A stalled out1 does not block a packet to out0, unless out1 is the current route.
- `pkt_cnt0`/`pkt_cnt1`: increments on a channel accept with `outN_last`=1. Wraps 255 → 0.
- Data and last outputs are only meaningful while the channel is valid, but they hold their last loaded value.

## Timing
- Reset values:
  - state `IDLE`.
  - `out0_valid`, `out1_valid`, `out*_last` = 0.
  - `out*_data` = 0.
  - `pkt_cnt*` = 0.
  - `in_ready` = 1 from the first cycle after reset (registers empty).
- Reset mid-packet: in-flight register contents are discarded and the FSM returns to `IDLE`. The next accepted beat is treated as a first beat.
- Latency: accepted beat appears on `outN_valid` the next cycle.
- Throughput: 1 beat/cycle per route while the downstream holds ready high.
- Counter update is visible the cycle after the final-beat channel accept.
- Protocol: `outN_valid` never deasserts, and `outN_data`/`outN_last` never change, while valid is high and ready is low. The upstream is required to obey the same rule.

## Structure
- Package `demux_pkg`: FSM state encoding localparams (`IDLE`=2'd0, `ROUTE0`=2'd1, `ROUTE1`=2'd2) and the default `WIDTH`.
- Sub-module `demux_out_reg`, instantiated twice. It contains:
  - the one-entry data/last/valid register;
  - the load/drain logic;
  - the 8-bit packet counter.
- The top level holds the FSM, route mux and `in_ready` logic.

## Test plan
- Reset, then a 3-beat packet 0xA1, 0xA2, 0xA3(last) with `sel`=0 and `out0_ready`=1. Required: out0 shows the beats on cycles 1–3 after each accept, out1 stays idle, `pkt_cnt0`=1.
- `sel` toggles 0 → 1 mid-packet. Required: every beat of the packet goes to out0. The next packet, with `sel`=1 at its first beat, goes to out1.
- `out0_ready`=0 with out0 full, packet routed to out0. Required: `in_ready`=0 and out0 data held stable. After ready rises, the beats resume with none lost or duplicated.
- out1 stalled holding a beat, then a new packet with `sel`=0. Required: it flows to out0 at full rate while out1 still holds its beat.
- Back-to-back single-beat packets alternating `sel`, both readies high, 256 packets per channel. Required: one beat per cycle, and `pkt_cnt0`/`pkt_cnt1` wrap to 0.
- Assert `rst` after the 2nd beat of a 4-beat packet. Required: all valids drop to 0 and the FSM is `IDLE`. The next beat routes by current `sel`.
